aes_enc_round_ctrl: RTL and testbench

// - Iterative AES-128 encryption sequencer, one round per clock.
// - Holds the 128-bit state and the current round key, and sequences the existing AddRoundKey datapath with SubBytes/ShiftRows/MixColumns.
// - Runs the on-the-fly key schedule step.
// - Sits between the host plaintext/key source and the ciphertext sink, with valid/ready handshakes on both sides.

---
 rtl/aes_pkg.sv | 84 ++++++++
 rtl/aes_enc_round_ctrl_if.sv | 23 ++
 rtl/AddRoundKey.sv | 12 +
 rtl/aes_key_step.sv | 33 +++
 rtl/aes_enc_round_ctrl.sv | 113 +++++++++++
 tb/tb_aes_enc_round_ctrl.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 types, constants and byte-level transforms used by the
// iterative encryption controller and its key-schedule step.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_ctrl_state_e;

  localparam int NR_AES128 = 10;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse is b^254 built from the squares b^2..b^128; zero maps to zero.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = b;
    for (int i = 0; i < 7; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic aes_block_t sub_bytes(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  function automatic aes_block_t shift_rows(input aes_block_t s);
    aes_block_t o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic aes_block_t mix_columns(input aes_block_t s);
    aes_block_t o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_enc_round_ctrl_if.sv
// Host-side plaintext/key intake and sink-side ciphertext delivery, each
// with its own valid/ready handshake.
interface aes_enc_round_ctrl_if;

  logic                in_valid;
  logic                in_ready;
  aes_pkg::aes_block_t plaintext;
  aes_pkg::aes_block_t key;
  logic                out_valid;
  logic                out_ready;
  aes_pkg::aes_block_t ciphertext;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext
  );

endinterface

// File: rtl/AddRoundKey.sv
// AddRoundKey datapath: bitwise XOR of the AES state with a round key.
module AddRoundKey
  import aes_pkg::*;
(
  input  aes_block_t i_state,
  input  aes_block_t i_key,
  output aes_block_t o_state
);

  assign o_state = i_state ^ i_key;

endmodule

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the
// current one using RotWord, SubWord, the round constant and an XOR chain.
module aes_key_step
  import aes_pkg::*;
(
  input  aes_block_t rk_in,
  input  logic [7:0] rcon,
  output aes_block_t rk_out
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot;
  logic [31:0] w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign w_w0 = rk_in[127:96];
  assign w_w1 = rk_in[95:64];
  assign w_w2 = rk_in[63:32];
  assign w_w3 = rk_in[31:0];

  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_temp = {sbox(w_rot[31:24]) ^ rcon, sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  // Each new word folds in its freshly computed left neighbour.
  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign rk_out = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_enc_round_ctrl.sv
// Iterative AES-128 encryption sequencer: accepts a plaintext/key pair,
// runs one round per clock with an on-the-fly key schedule, then holds the
// ciphertext until the sink takes it.
module aes_enc_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  aes_enc_round_ctrl_if.slave  bus,
  output logic [3:0]           round_o
);

  if (NR != NR_AES128) begin : g_bad_nr
    $error("aes_enc_round_ctrl: only NR=10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  aes_ctrl_state_e r_fsm, w_fsmNext;
  aes_block_t      r_state, r_roundKey;
  logic [3:0]      r_round;

  logic            w_accept, w_step, w_retire, w_lastRound;
  logic [7:0]      w_rcon;
  aes_block_t      w_rkNext, w_subShift, w_mixed, w_arkInit, w_arkRound;

  assign w_lastRound = (r_round == LAST_ROUND);
  assign w_rcon      = (r_round >= 4'd1 && r_round <= LAST_ROUND) ?
                       RCON[r_round - 4'd1] : 8'h00;

  aes_key_step u_keyStep (
    .rk_in  (r_roundKey),
    .rcon   (w_rcon),
    .rk_out (w_rkNext)
  );

  // The final round skips MixColumns.
  assign w_subShift = shift_rows(sub_bytes(r_state));
  assign w_mixed    = w_lastRound ? w_subShift : mix_columns(w_subShift);

  AddRoundKey u_arkInit (
    .i_state (bus.plaintext),
    .i_key   (bus.key),
    .o_state (w_arkInit)
  );

  AddRoundKey u_arkRound (
    .i_state (w_mixed),
    .i_key   (w_rkNext),
    .o_state (w_arkRound)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_fsm <= IDLE;
    else        r_fsm <= w_fsmNext;
  end

  always_comb begin
    w_fsmNext     = r_fsm;
    w_accept      = 1'b0;
    w_step        = 1'b0;
    w_retire      = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_accept  = 1'b1;
          w_fsmNext = ROUND;
        end
      end
      ROUND: begin
        w_step = 1'b1;
        if (w_lastRound) w_fsmNext = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_retire  = 1'b1;
          w_fsmNext = IDLE;
        end
      end
      default: w_fsmNext = IDLE;
    endcase
  end

  // The round counter parks at the last round so DONE still reports it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= '0;
      r_roundKey <= '0;
      r_round    <= '0;
    end else if (w_accept) begin
      r_state    <= w_arkInit;
      r_roundKey <= bus.key;
      r_round    <= 4'd1;
    end else if (w_step) begin
      r_state    <= w_arkRound;
      r_roundKey <= w_rkNext;
      if (!w_lastRound) r_round <= r_round + 4'd1;
    end else if (w_retire) begin
      r_round    <= '0;
    end
  end

  assign bus.ciphertext = bus.out_valid ? r_state : '0;
  assign round_o        = r_round;

endmodule

// File: tb/tb_aes_enc_round_ctrl.sv
// Bench for aes_enc_round_ctrl: FIPS-197 vectors, backpressure, back-to-back
// and mid-block reset, plus random blocks against a table-driven AES model.
module tb_aes_enc_round_ctrl;

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ARK_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] round_o;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] sb [256];

  aes_enc_round_ctrl_if bus();

  aes_enc_round_ctrl #(.NR(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .round_o (round_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // S-box from the multiplicative-group walk (p steps by 3, q by 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Full key expansion up front, then ten rounds over a byte array.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = m2(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row+4*col] = t[row+4*((col+row)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
          s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Offer one block for exactly one edge, then scramble the data lines.
  task automatic do_accept(input logic [127:0] pt, input logic [127:0] k);
    bus.in_valid  = 1'b1;
    bus.plaintext = pt;
    bus.key       = k;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
    bus.key       = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input string name);
    int cyc;
    do_accept(pt, k);
    wait_done(cyc);
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL %s_latency: got %0d cycles want 10", name, cyc); end
    checks++; if (bus.ciphertext !== exp) begin errors++; $display("[TB] FAIL %s_ct: got %h want %h", name, bus.ciphertext, exp); end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.ciphertext !== exp) begin errors++; $display("[TB] FAIL %s_hold: got valid=%b ct=%h want valid=1 ct=%h", name, bus.out_valid, bus.ciphertext, exp); end
    pop();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s_retire: got in_ready=%b out_valid=%b want 1/0", name, bus.in_ready, bus.out_valid); end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.plaintext = '0;
    bus.key       = '0;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.ciphertext !== 128'h0) begin errors++; $display("[TB] FAIL reset_ct: got %h want 0", bus.ciphertext); end
    checks++; if (round_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_round: got %0d want 0", round_o); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || round_o !== 4'd0) begin errors++; $display("[TB] FAIL idle_after_reset: got in_ready=%b round=%0d want 1/0", bus.in_ready, round_o); end
  endtask

  task automatic test_fips_b();
    int cyc;
    int bad;
    do_accept(PT_B, KEY_B);
    checks++; if (dut.r_state !== ARK_B) begin errors++; $display("[TB] FAIL b_round0_state: got %h want %h", dut.r_state, ARK_B); end
    cyc = 0;
    bad = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      if (round_o !== 4'(cyc + 1) || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
      cyc++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL b_round_progress: got %0d bad cycles want 0", bad); end
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL b_latency: got %0d cycles want 10", cyc); end
    checks++; if (bus.ciphertext !== CT_B) begin errors++; $display("[TB] FAIL b_ct: got %h want %h", bus.ciphertext, CT_B); end
    checks++; if (round_o !== 4'd10) begin errors++; $display("[TB] FAIL b_done_round: got %0d want 10", round_o); end
    pop();
    checks++; if (bus.in_ready !== 1'b1 || bus.ciphertext !== 128'h0 || round_o !== 4'd0) begin errors++; $display("[TB] FAIL b_retire: got in_ready=%b ct=%h round=%0d want 1/0/0", bus.in_ready, bus.ciphertext, round_o); end
  endtask

  task automatic test_backpressure();
    int cyc;
    do_accept(PT_B, KEY_B);
    wait_done(cyc);
    checks++; if (cyc != 10) begin errors++; $display("[TB] FAIL bp_latency: got %0d cycles want 10", cyc); end
    bus.in_valid  = 1'b1;
    bus.plaintext = PT_C;
    bus.key       = KEY_C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.ciphertext !== CT_B || bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_hold%0d: got valid=%b in_ready=%b ct=%h want 1/0/%h", i, bus.out_valid, bus.in_ready, bus.ciphertext, CT_B); end
    end
    bus.in_valid = 1'b0;
    pop();
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || round_o !== 4'd0) begin errors++; $display("[TB] FAIL bp_release: got in_ready=%b valid=%b round=%0d want 1/0/0", bus.in_ready, bus.out_valid, round_o); end
    @(negedge clk);
    checks++; if (round_o !== 4'd0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_accept: got round=%0d in_ready=%b want 0/1", round_o, bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] outs[$];
    int acc [2];
    int nacc;
    nacc          = 0;
    acc[0]        = -1;
    acc[1]        = -1;
    bus.in_valid  = 1'b1;
    bus.plaintext = PT_B;
    bus.key       = KEY_B;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (bus.out_valid === 1'b1) outs.push_back(bus.ciphertext);
      if (nacc == 1) begin bus.plaintext = PT_C; bus.key = KEY_C; end
      if (nacc == 2) bus.in_valid = 1'b0;
      if (bus.in_ready === 1'b1 && bus.in_valid === 1'b1) begin acc[nacc] = t; nacc++; end
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++; if (nacc != 2) begin errors++; $display("[TB] FAIL b2b_accepts: got %0d want 2", nacc); end
    checks++; if (acc[1] - acc[0] != 12) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d cycles want 12", acc[1] - acc[0]); end
    checks++; if (outs.size() != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d results want 2", outs.size()); end
    if (outs.size() == 2) begin
      checks++; if (outs[0] !== CT_B) begin errors++; $display("[TB] FAIL b2b_first: got %h want %h", outs[0], CT_B); end
      checks++; if (outs[1] !== CT_C) begin errors++; $display("[TB] FAIL b2b_second: got %h want %h", outs[1], CT_C); end
    end
  endtask

  task automatic test_reset_midop();
    int cyc;
    do_accept(PT_B, KEY_B);
    cyc = 0;
    while (round_o !== 4'd5 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (round_o !== 4'd5) begin errors++; $display("[TB] FAIL mid_reach5: got round=%0d want 5", round_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.ciphertext !== 128'h0) begin errors++; $display("[TB] FAIL mid_outputs: got valid=%b ct=%h want 0/0", bus.out_valid, bus.ciphertext); end
    checks++; if (round_o !== 4'd0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_status: got round=%0d in_ready=%b want 0/1", round_o, bus.in_ready); end
    checks++; if (dut.r_state !== 128'h0) begin errors++; $display("[TB] FAIL mid_state_clear: got %h want 0", dut.r_state); end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (round_o !== 4'd0 || bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release: got round=%0d in_ready=%b want 0/1", round_o, bus.in_ready); end
    run_block(PT_C, KEY_C, CT_C, "mid_c1");
  endtask

  task automatic test_random();
    logic [127:0] pt, k;
    for (int n = 0; n < 8; n++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      run_block(pt, k, aes_ref(pt, k), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    run_block(PT_C, KEY_C, CT_C, "fips_c1");
    run_block(128'h0, 128'h0, CT_Z, "all_zero");
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
